// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the UART RX control FSM and its datapath
// (sampler, deserializer, start/parity/stop checkers).
// master: the FSM (drives enables, counters, data_valid).
// slave : the datapath (drives checker results back).
interface uart_rx_fsm_if #(
  parameter int PRESCALE_W = 6
);
  logic                  dat_samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  deser_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic                  par_err;
  logic                  strt_glitch;
  logic                  stp_err;

  modport master (
    output dat_samp_en, edge_cnt, bit_cnt, deser_en,
           strt_chk_en, par_chk_en, stp_chk_en, data_valid,
    input  par_err, strt_glitch, stp_err
  );

  modport slave (
    input  dat_samp_en, edge_cnt, bit_cnt, deser_en,
           strt_chk_en, par_chk_en, stp_chk_en, data_valid,
    output par_err, strt_glitch, stp_err
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM.
// Frame: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// Owns the oversampling edge counter and bit counter, strobes the sampler,
// deserializer and checkers, and pulses data_valid once per good frame.
// Optional build macro UART_RX_ERR_CNT_EN adds a saturating 8-bit count
// of dropped frames on port err_cnt.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  uart_rx_fsm_if.master         ctl
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state;
  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] edge_q;
  logic [3:0]            bit_q;
  logic                  dv_q;

  // Bit-timing landmarks derived from the prescale latched at frame start.
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] strb_edge;
  logic [PRESCALE_W-1:0] last_edge;
  logic                  end_of_bit;
  logic                  at_strb;
  logic [PRESCALE_W-1:0] edge_nxt;
  logic [3:0]            bit_nxt;
  logic                  last_data;

  assign half       = presc_q >> 1;
  // Sampler votes at H-1, H, H+1; its result is stable from H+2.
  assign strb_edge  = half + PRESCALE_W'(2);
  assign last_edge  = presc_q - PRESCALE_W'(1);
  assign end_of_bit = (edge_q == last_edge);
  assign at_strb    = (edge_q == strb_edge);
  assign last_data  = (bit_q == 4'(DATA_WIDTH));

  // Free-running advance used by every active state; wraps at end of bit.
  assign edge_nxt = end_of_bit ? '0 : edge_q + PRESCALE_W'(1);
  assign bit_nxt  = end_of_bit ? bit_q + 4'd1 : bit_q;

  // Drop conditions are also what the optional error counter counts.
  logic drop;
  assign drop = end_of_bit &&
                (((state == START)  && ctl.strt_glitch) ||
                 ((state == PARITY) && ctl.par_err)     ||
                 ((state == STOP)   && ctl.stp_err));

  // Main FSM: state, counters, latched prescale and registered data_valid.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      presc_q <= '0;
      edge_q  <= '0;
      bit_q   <= '0;
      dv_q    <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state)
        IDLE: begin
          edge_q <= '0;
          bit_q  <= '0;
          if (!RX_IN) begin
            state   <= START;
            presc_q <= Prescale;
          end
        end

        START: begin
          edge_q <= edge_nxt;
          bit_q  <= bit_nxt;
          if (end_of_bit) begin
            if (ctl.strt_glitch) begin
              state  <= IDLE;
              edge_q <= '0;
              bit_q  <= '0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          edge_q <= edge_nxt;
          bit_q  <= bit_nxt;
          // PAR_EN only matters here, so a mid-frame change cannot
          // split one frame across two formats.
          if (end_of_bit && last_data)
            state <= PAR_EN ? PARITY : STOP;
        end

        PARITY: begin
          edge_q <= edge_nxt;
          bit_q  <= bit_nxt;
          if (end_of_bit) begin
            if (ctl.par_err) begin
              state  <= IDLE;
              edge_q <= '0;
              bit_q  <= '0;
            end else begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          edge_q <= edge_nxt;
          bit_q  <= bit_nxt;
          if (end_of_bit) begin
            edge_q <= '0;
            bit_q  <= '0;
            if (ctl.stp_err) begin
              state <= IDLE;
            end else begin
              dv_q <= 1'b1;
              // Line already low at stop end: next start bit follows
              // directly, so skip IDLE and re-latch the prescale.
              if (!RX_IN) begin
                state   <= START;
                presc_q <= Prescale;
              end else begin
                state <= IDLE;
              end
            end
          end
        end

        default: begin
          state  <= IDLE;
          edge_q <= '0;
          bit_q  <= '0;
        end
      endcase
    end
  end

  logic samp_en, deser_en, strt_en, par_en, stp_en;

  // One-cycle strobes decoded from state and edge position; zero in IDLE
  // and in any unused encoding.
  always_comb begin
    samp_en  = 1'b0;
    deser_en = 1'b0;
    strt_en  = 1'b0;
    par_en   = 1'b0;
    stp_en   = 1'b0;
    case (state)
      START: begin
        samp_en = 1'b1;
        strt_en = at_strb;
      end
      DATA: begin
        samp_en  = 1'b1;
        deser_en = at_strb;
      end
      PARITY: begin
        samp_en = 1'b1;
        par_en  = at_strb;
      end
      STOP: begin
        samp_en = 1'b1;
        stp_en  = at_strb;
      end
      default: ;
    endcase
  end

  assign ctl.dat_samp_en = samp_en;
  assign ctl.edge_cnt    = edge_q;
  assign ctl.bit_cnt     = bit_q;
  assign ctl.deser_en    = deser_en;
  assign ctl.strt_chk_en = strt_en;
  assign ctl.par_chk_en  = par_en;
  assign ctl.stp_chk_en  = stp_en;
  assign ctl.data_valid  = dv_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_q;

  // Saturating count of frames dropped by any checker.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      err_q <= '0;
    else if (drop && (err_q != 8'hFF))
      err_q <= err_q + 8'd1;
  end

  assign err_cnt = err_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
